rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
- Instruction-fetch initiator for the RV32I pipeline.
- Drives the word address into the synchronous instruction memory, which has 1-cycle read latency and no read enable. The memory samples the address every posedge and returns the instruction on the next cycle.
- Tracks in-flight requests and buffers returned instructions in a small FIFO.
- Presents {pc, inst} to decode over a valid/ready handshake, and handles branch/jump redirects by flushing all in-flight and buffered work.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset. Bits [1:0] must be 0.
- DEPTH, 2, output FIFO entries. Minimum 2; 2 is needed for full throughput.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  out  XLEN  byte address to the instruction memory. Bits [1:0] are always 0.
- imem_inst  in  XLEN  memory read data; valid 1 cycle after imem_addr is sampled.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  redirect target. Bits [1:0] are ignored and forced to 0.
- fetch_valid  out  1  a buffered instruction is available to decode.
- fetch_ready  in  1  decode accepts the head entry this cycle.
- fetch_inst  out  XLEN  head instruction.
- fetch_pc  out  XLEN  byte address of the head instruction.

Behaviour:
- State:
  - pc_req: next address to request. imem_addr = pc_req.
  - inflight_q, inflight_pc: a request was issued at the last edge, and its data is on imem_inst this cycle.
  - FIFO of {pc, inst} with count_q in 0..DEPTH.
- Reset (asynchronous): pc_req = RESET_PC, inflight_q = 0, count_q = 0, FIFO contents = 0, fetch_valid = 0, fetch_inst = 0, fetch_pc = 0.
  - The memory's reset output value of 0 is never pushed, because inflight_q = 0.
- Combinational signals:
  - pop = fetch_valid & fetch_ready.
  - push = inflight_q & !redirect_valid.
  - issue = !redirect_valid & (count_q + inflight_q - pop < DEPTH).
- fetch_valid = (count_q != 0) & !redirect_valid. fetch_inst and fetch_pc show the head entry, or 0 when the FIFO is empty.
- Normal edge (no redirect):
  - push writes {inflight_pc, imem_inst} at the tail.
  - pop removes the head.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
  - On issue: inflight_pc <= pc_req, pc_req <= pc_req + 4, inflight_q <= 1. Otherwise inflight_q <= 0 and pc_req holds. The memory re-reads the held address and the result is ignored.
- Redirect edge (highest priority; overrides push, pop and issue):
  - count_q <= 0 and inflight_q <= 0; arriving data is dropped.
  - pc_req <= {redirect_pc[XLEN-1:2], 2'b00}.
  - The request the memory samples at this edge is discarded. Back-to-back redirects: the last one wins.
- Latency:
  - First request is issued at the first edge after rst deasserts; fetch_valid rises after the second edge.
  - redirect_valid high in cycle n → target appears with fetch_valid = 1 in cycle n+3.
- Throughput: with fetch_ready held high, one instruction per cycle in steady state (count_q = 1, inflight_q = 1).
- Backpressure: count_q + inflight_q never exceeds DEPTH, so no response is ever lost. FIFO overflow is impossible by construction; the bench asserts it.
- Wrap: pc_req increments modulo 2^XLEN; 32'hFFFF_FFFC → 32'h0000_0000.
- Reset mid-operation: all state returns to reset values immediately; in-flight data is discarded.

Test Plan:
- Streaming: memory model mem[i] = 32'hA000_0000 + i, RESET_PC = 0, fetch_ready = 1.
  - Required: fetch_valid rises 2 edges after reset release.
  - Then pairs (pc, inst) = (0x0, A0000000), (0x4, A0000001), (0x8, A0000002)…, one per cycle with no gaps.
- Backpressure: stream, then hold fetch_ready = 0 for 5 cycles and release.
  - Required: fetch_pc/fetch_inst stable while stalled; count_q saturates at 2.
  - After release, the sequence continues with no skipped or duplicated pc.
- Redirect: while streaming, assert redirect_valid in one cycle with redirect_pc = 0x40.
  - Required: fetch_valid = 0 in that cycle and the next two; in cycle n+3, fetch_pc = 0x40 and fetch_inst = A0000010, then 0x44 next.
- Redirect during stall with misalignment: FIFO full, fetch_ready = 0, redirect_pc = 0x103.
  - Required: FIFO flushed; next delivered fetch_pc = 0x100, inst = A0000040.
- Back-to-back redirects and wrap:
  - Redirects to 0x20 then 0x80 on consecutive cycles → only 0x80 and successors are delivered.
  - Redirect to 0xFFFF_FFFC → pcs 0xFFFF_FFFC then 0x0000_0000.
- Async reset mid-stream: rst pulsed between edges → fetch_valid = 0 and imem_addr = RESET_PC immediately; the stream restarts from RESET_PC with the same latency as power-on.

Source files
------------

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction-fetch initiator: issues word addresses to a 1-cycle
// synchronous instruction memory, buffers returned words in a small FIFO and
// presents {pc, inst} to decode over valid/ready. Redirects flush everything.
module rv32i_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_inst,
    output logic [XLEN-1:0] fetch_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Request side
    logic [XLEN-1:0] pc_req;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight_q;

    // Output FIFO
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] fifo_inst [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;
    logic            fifo_nonempty;

    // The low two redirect bits are intentionally dropped (word alignment).
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_nonempty = (count_q != '0);
    assign fetch_valid   = fifo_nonempty && !redirect_valid;
    assign fetch_inst    = fifo_nonempty ? fifo_inst[head_q] : '0;
    assign fetch_pc      = fifo_nonempty ? fifo_pc[head_q]   : '0;
    assign imem_addr     = pc_req;

    assign pop  = fetch_valid && fetch_ready;
    assign push = inflight_q && !redirect_valid;

    // Committed slots after this edge: buffered + returning - leaving. A new
    // request is only allowed if its response is guaranteed a FIFO slot.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue     = !redirect_valid && (occupancy < (CW+1)'(DEPTH));

    // Request address, in-flight tracking; redirect restarts at aligned target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_req      <= RESET_PC;
            inflight_pc <= '0;
            inflight_q  <= 1'b0;
        end else if (redirect_valid) begin
            pc_req     <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight_q <= 1'b0;
        end else if (issue) begin
            inflight_pc <= pc_req;
            pc_req      <= pc_req + XLEN'(4);
            inflight_q  <= 1'b1;
        end else begin
            inflight_q  <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (redirect_valid) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            if (push) begin
                tail_q <= ptr_inc(tail_q);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // One storage register pair per FIFO entry, written when it is the tail
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Capture returning {pc, inst} into this entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                fifo_pc[gi]   <= '0;
                fifo_inst[gi] <= '0;
            end else if (push && (tail_q == PW'(gi))) begin
                fifo_pc[gi]   <= inflight_pc;
                fifo_inst[gi] <= imem_inst;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit: streaming, backpressure, redirects,
// misaligned redirect during stall, back-to-back redirects, wrap, async reset.
module tb_rv32i_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_valid;
    logic        fetch_ready = 1'b1;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;

    int vectors = 0;
    int miscompares = 0;

    rv32i_fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_inst(imem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_inst(fetch_inst),
        .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    // Synchronous instruction memory: 1-cycle latency, no enable
    always @(posedge clk) begin
        imem_inst <= mem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'h0, fetch_valid}, 32'h1);
        check({tag, ".pc"}, fetch_pc, pc);
        check({tag, ".inst"}, fetch_inst, mem_word(pc));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, {31'h0, fetch_valid}, 32'h0);
    endtask

    // Advance to the next falling edge and check the no-overflow invariant
    task automatic tick();
        @(negedge clk);
        vectors++;
        assert ((32'(dut.count_q) + 32'(dut.inflight_q)) <= 32'd2) else begin
            miscompares++;
            $error("FAIL occupancy: observed %0d expected <= 2",
                   32'(dut.count_q) + 32'(dut.inflight_q));
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        #1;
        check_idle("rst");
        check("rst.addr", imem_addr, 32'h0);
        check("rst.pc", fetch_pc, 32'h0);
        check("rst.inst", fetch_inst, 32'h0);

        // Streaming from RESET_PC: valid after the second edge
        tick(); rst = 1'b0; #1;
        check_idle("boot0");
        tick(); #1;
        check_idle("boot1");
        check("boot1.addr", imem_addr, 32'h4);
        tick(); #1;
        check_head("stream0", 32'h0);
        for (int k = 1; k < 8; k++) begin
            tick(); #1;
            check_head("stream", 32'(4 * k));
        end

        // Backpressure: 5 stalled cycles, head must not move
        tick(); fetch_ready = 1'b0; #1;
        check_head("stall0", 32'h20);
        for (int s = 1; s < 5; s++) begin
            tick(); #1;
            check_head("stall", 32'h20);
            check("stall.count", 32'(dut.count_q), 32'h2);
        end
        tick(); fetch_ready = 1'b1; #1;
        check_head("release", 32'h20);
        for (int k = 1; k < 7; k++) begin
            tick(); #1;
            check_head("resume", 32'(32'h20 + 4 * k));
        end

        // Redirect while streaming: target appears in cycle n+3
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        check_idle("redir.n0");
        tick(); redirect_valid = 1'b0; #1;
        check_idle("redir.n1");
        tick(); #1;
        check_idle("redir.n2");
        tick(); #1;
        check_head("redir.n3", 32'h40);
        tick(); #1;
        check_head("redir.n4", 32'h44);
        tick(); #1;
        check_head("redir.n5", 32'h48);

        // Misaligned redirect while full and stalled
        tick(); fetch_ready = 1'b0; #1;
        check_head("fill0", 32'h4C);
        tick(); #1;
        tick(); #1;
        check("fill.count", 32'(dut.count_q), 32'h2);
        check_head("fill2", 32'h4C);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        check_idle("mis.n0");
        tick(); redirect_valid = 1'b0; fetch_ready = 1'b1; #1;
        check_idle("mis.n1");
        check("mis.flush", 32'(dut.count_q), 32'h0);
        tick(); #1;
        check_idle("mis.n2");
        tick(); #1;
        check_head("mis.n3", 32'h100);
        tick(); #1;
        check_head("mis.n4", 32'h104);

        // Back-to-back redirects: the second one wins
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h20; #1;
        check_idle("b2b.n0");
        tick(); redirect_pc = 32'h80; #1;
        check_idle("b2b.n1");
        tick(); redirect_valid = 1'b0; #1;
        check_idle("b2b.n2");
        tick(); #1;
        check_idle("b2b.n3");
        tick(); #1;
        check_head("b2b.n4", 32'h80);
        tick(); #1;
        check_head("b2b.n5", 32'h84);

        // Address wrap at the top of the space
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        check_idle("wrap.n0");
        tick(); redirect_valid = 1'b0; #1;
        check_idle("wrap.n1");
        tick(); #1;
        check_idle("wrap.n2");
        tick(); #1;
        check_head("wrap.top", 32'hFFFF_FFFC);
        check("wrap.top.inst_const", fetch_inst, 32'hDFFF_FFFF);
        tick(); #1;
        check_head("wrap.zero", 32'h0);
        tick(); #1;
        check_head("wrap.four", 32'h4);
        tick(); #1;
        check_head("wrap.eight", 32'h8);

        // Asynchronous reset pulsed between edges
        tick(); #1;
        rst = 1'b1; #1;
        check_idle("arst");
        check("arst.addr", imem_addr, 32'h0);
        check("arst.pc", fetch_pc, 32'h0);
        check("arst.count", 32'(dut.count_q), 32'h0);
        #1; rst = 1'b0;
        tick(); #1;
        check_idle("arst.c1");
        check("arst.c1.addr", imem_addr, 32'h4);
        tick(); #1;
        check_head("arst.c2", 32'h0);
        tick(); #1;
        check_head("arst.c3", 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
